spsram_arb: RTL and testbench

Two-requester arbiter and sequencer for the single-port SRAM (`spsram`). It accepts read/write requests from two masters over valid/ready handshakes, grants one per cycle using round-robin, and drives the SRAM pins from registers. It returns read data to the originating requester with a fixed latency. After every reset it zero-fills the whole array before accepting traffic.

---
 rtl/spsram_arb.sv | 130 +++++++++++++
 tb/tb_spsram_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spsram_arb.sv
// Two-requester round-robin arbiter and sequencer for a single-port SRAM.
// Zero-fills the array after every reset, then issues one access per cycle.
module spsram_arb #(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_req0_valid,
  input  logic               i_req0_wr,
  input  logic [BW_ADDR-1:0] i_req0_addr,
  input  logic [BW_DATA-1:0] i_req0_data,
  input  logic               i_req1_valid,
  input  logic               i_req1_wr,
  input  logic [BW_ADDR-1:0] i_req1_addr,
  input  logic [BW_DATA-1:0] i_req1_data,
  output logic               o_req0_ready,
  output logic               o_req1_ready,
  output logic               o_rsp0_valid,
  output logic [BW_DATA-1:0] o_rsp0_data,
  output logic               o_rsp1_valid,
  output logic [BW_DATA-1:0] o_rsp1_data,
  output logic               o_init_done,
  output logic [BW_DATA-1:0] o_mem_data,
  output logic [BW_ADDR-1:0] o_mem_addr,
  output logic               o_mem_wen,
  output logic               o_mem_cen,
  output logic               o_mem_oen,
  input  logic [BW_DATA-1:0] i_mem_data
);

  typedef enum logic {INIT, RUN} state_t;

  state_t             state, state_nx;
  logic [BW_ADDR-1:0] init_cnt;
  logic               rr_ptr;
  logic               gnt0, gnt1, gnt;
  logic               sel_wr;
  logic [BW_ADDR-1:0] sel_addr;
  logic [BW_DATA-1:0] sel_data;
  logic               t1_rd, t1_id, t2_rd, t2_id;

  always_comb begin
    state_nx = state;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    case (state)
      INIT: if (init_cnt == '1) state_nx = RUN;
      RUN: begin
        // rr_ptr == 0 gives requester 0 priority on contention
        gnt0 = i_req0_valid && (!i_req1_valid || !rr_ptr);
        gnt1 = i_req1_valid && !gnt0;
      end
      default: state_nx = INIT;
    endcase
  end

  assign gnt          = gnt0 | gnt1;
  assign o_req0_ready = gnt0 & i_rstn;
  assign o_req1_ready = gnt1 & i_rstn;
  assign sel_wr       = gnt1 ? i_req1_wr   : i_req0_wr;
  assign sel_addr     = gnt1 ? i_req1_addr : i_req0_addr;
  assign sel_data     = gnt1 ? i_req1_data : i_req0_data;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state       <= INIT;
      init_cnt    <= '0;
      rr_ptr      <= 1'b0;
      o_init_done <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == '1) o_init_done <= 1'b1;
      end
      if (gnt) rr_ptr <= gnt0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_mem_cen  <= 1'b0;
      o_mem_wen  <= 1'b0;
      o_mem_oen  <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
    end else if (state == INIT) begin
      o_mem_cen  <= 1'b1;
      o_mem_wen  <= 1'b1;
      o_mem_oen  <= 1'b0;
      o_mem_addr <= init_cnt;
      o_mem_data <= '0;
    end else if (gnt) begin
      o_mem_cen  <= 1'b1;
      o_mem_wen  <= sel_wr;
      o_mem_oen  <= !sel_wr;
      o_mem_addr <= sel_addr;
      if (sel_wr) o_mem_data <= sel_data;
    end else begin
      o_mem_cen <= 1'b0;
      o_mem_wen <= 1'b0;
      o_mem_oen <= 1'b0;
    end
  end

  // Tag follows the command through the SRAM's one-cycle read latency
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      t1_rd        <= 1'b0;
      t1_id        <= 1'b0;
      t2_rd        <= 1'b0;
      t2_id        <= 1'b0;
      o_rsp0_valid <= 1'b0;
      o_rsp1_valid <= 1'b0;
      o_rsp0_data  <= '0;
      o_rsp1_data  <= '0;
    end else begin
      t1_rd        <= gnt && !sel_wr;
      t1_id        <= gnt1;
      t2_rd        <= t1_rd;
      t2_id        <= t1_id;
      o_rsp0_valid <= t2_rd && !t2_id;
      o_rsp1_valid <= t2_rd && t2_id;
      if (t2_rd && !t2_id) o_rsp0_data <= i_mem_data;
      if (t2_rd && t2_id)  o_rsp1_data <= i_mem_data;
    end
  end

endmodule

// File: tb/tb_spsram_arb.sv
// Bench for spsram_arb: directed scenarios plus random traffic, checked each
// cycle against a transaction-level model of memory contents and responses.
module tb_spsram_arb;
  localparam int BW_DATA = 32;
  localparam int BW_ADDR = 5;
  localparam int NW      = 1 << BW_ADDR;

  logic               clk, rstn;
  logic               v0, wr0, v1, wr1;
  logic [BW_ADDR-1:0] a0, a1;
  logic [BW_DATA-1:0] d0, d1;
  logic               r0, r1, rv0, rv1, init_done;
  logic [BW_DATA-1:0] rd0, rd1, mem_wdata, mem_rdata;
  logic [BW_ADDR-1:0] mem_addr;
  logic               mem_wen, mem_cen, mem_oen;

  spsram_arb #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_req0_valid(v0), .i_req0_wr(wr0), .i_req0_addr(a0), .i_req0_data(d0),
    .i_req1_valid(v1), .i_req1_wr(wr1), .i_req1_addr(a1), .i_req1_data(d1),
    .o_req0_ready(r0), .o_req1_ready(r1),
    .o_rsp0_valid(rv0), .o_rsp0_data(rd0),
    .o_rsp1_valid(rv1), .o_rsp1_data(rd1),
    .o_init_done(init_done),
    .o_mem_data(mem_wdata), .o_mem_addr(mem_addr),
    .o_mem_wen(mem_wen), .o_mem_cen(mem_cen), .o_mem_oen(mem_oen),
    .i_mem_data(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached single-port SRAM: registered read data
  logic [BW_DATA-1:0] sram [NW];
  initial begin
    for (int i = 0; i < NW; i++) sram[i] = '0;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_cen) begin
      if (mem_wen) sram[mem_addr] <= mem_wdata;
      if (mem_oen) mem_rdata <= sram[mem_addr];
    end
  end

  typedef struct {
    int               due;
    bit               id;
    logic [BW_DATA-1:0] data;
  } rsp_t;

  int checks, errors;
  int cyc;
  bit ptr;
  logic [BW_DATA-1:0] ref_mem [NW];
  rsp_t rsp_q[$];
  bit cmd_pend, cmd_wr;
  logic [BW_ADDR-1:0] cmd_addr, e_addr;
  logic [BW_DATA-1:0] cmd_data, e_data;
  bit acc0, acc1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    bit er0, er1, e_cen, e_wen, e_oen, e_rv0, e_rv1;
    rsp_t e;
    @(negedge clk);
    er0 = (cyc >= NW) && v0 && (!v1 || !ptr);
    er1 = (cyc >= NW) && v1 && !er0;
    chk("ready0", r0, er0);
    chk("ready1", r1, er1);
    chk("init_done", init_done, cyc >= NW);
    e_cen = 1'b0; e_wen = 1'b0; e_oen = 1'b0;
    if (cyc >= 1 && cyc <= NW) begin
      e_cen = 1'b1; e_wen = 1'b1;
      e_addr = BW_ADDR'(cyc - 1);
      e_data = '0;
    end else if (cmd_pend) begin
      e_cen = 1'b1; e_wen = cmd_wr; e_oen = !cmd_wr;
      e_addr = cmd_addr;
      if (cmd_wr) e_data = cmd_data;
    end
    chk("mem_cen", mem_cen, e_cen);
    chk("mem_wen", mem_wen, e_wen);
    chk("mem_oen", mem_oen, e_oen);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_data", mem_wdata, e_data);
    e_rv0 = 1'b0; e_rv1 = 1'b0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      e = rsp_q.pop_front();
      if (e.id) begin e_rv1 = 1'b1; chk("rsp1_data", rd1, e.data); end
      else      begin e_rv0 = 1'b1; chk("rsp0_data", rd0, e.data); end
    end
    chk("rsp0_valid", rv0, e_rv0);
    chk("rsp1_valid", rv1, e_rv1);
    cmd_pend = er0 || er1;
    if (cmd_pend) begin
      cmd_wr   = er1 ? wr1 : wr0;
      cmd_addr = er1 ? a1  : a0;
      cmd_data = er1 ? d1  : d0;
      if (cmd_wr) ref_mem[cmd_addr] = cmd_data;
      else rsp_q.push_back('{due: cyc + 3, id: er1, data: ref_mem[cmd_addr]});
      ptr = er0;
    end
    acc0 = er0;
    acc1 = er1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0; v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    chk("rst_ready0", r0, 1'b0);
    chk("rst_ready1", r1, 1'b0);
    @(posedge clk); #1;
    repeat (n) begin
      @(negedge clk);
      chk("rst_outs", {r0, r1, rv0, rv1, init_done, mem_wen, mem_cen, mem_oen}, 8'h0);
      chk("rst_rsp0_data", rd0, '0);
      chk("rst_rsp1_data", rd1, '0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_data", mem_wdata, '0);
      @(posedge clk); #1;
    end
    rstn = 1'b1;
    cyc = 0; ptr = 1'b0; cmd_pend = 1'b0;
    e_addr = '0; e_data = '0;
    rsp_q.delete();
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
  endtask

  task automatic issue(input bit id, input bit wr, input logic [BW_ADDR-1:0] a,
                       input logic [BW_DATA-1:0] d);
    bit got;
    if (id) begin v1 = 1'b1; wr1 = wr; a1 = a; d1 = d; end
    else    begin v0 = 1'b1; wr0 = wr; a0 = a; d0 = d; end
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      step();
      got = id ? acc1 : acc0;
    end
    chk("accept_in_time", got, 1'b1);
    if (id) v1 = 1'b0; else v0 = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    v0 = 0; v1 = 0; wr0 = 0; wr1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    rstn = 1'b0;

    // Zero-fill after reset, then read back addr 17
    do_reset(3);
    repeat (NW) step();
    issue(0, 0, 17, '0);
    repeat (4) step();

    // req0 writes i to addr i back-to-back, then reads all back
    for (int i = 0; i < NW; i++) issue(0, 1, BW_ADDR'(i), BW_DATA'(i));
    for (int i = 0; i < NW; i++) issue(0, 0, BW_ADDR'(i), '0);
    repeat (4) step();

    // Write from req1 followed immediately by read from req0, same address
    issue(1, 1, 9, 32'hDEADBEEF);
    issue(0, 0, 9, '0);
    repeat (4) step();

    // req1 alone for 5 cycles, then both contend on reads of 3 and 4
    v1 = 1'b1; wr1 = 1'b0;
    for (int i = 0; i < 5; i++) begin a1 = BW_ADDR'($urandom); step(); end
    v0 = 1'b1; wr0 = 1'b0; a0 = 3;
    a1 = 4;
    repeat (8) step();
    v0 = 1'b0; v1 = 1'b0;
    repeat (4) step();

    // Random traffic; payload held until accepted
    acc0 = 1'b1; acc1 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!v0 || acc0) begin
        v0 = ($urandom_range(0, 3) != 0); wr0 = $urandom;
        a0 = BW_ADDR'($urandom); d0 = $urandom;
      end
      if (!v1 || acc1) begin
        v1 = ($urandom_range(0, 3) != 0); wr1 = $urandom;
        a1 = BW_ADDR'($urandom); d1 = $urandom;
      end
      step();
    end
    v0 = 1'b0; v1 = 1'b0;
    repeat (4) step();

    // Reset one cycle after a read accept: no response, fill restarts
    issue(0, 0, 5, '0);
    do_reset(3);
    repeat (NW + 2) step();
    issue(1, 0, 5, '0);
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
